// File: rtl/hilo_md_ctrl.sv
// Iterative multiply/divide sequencer for the EX stage: shift-add multiplier and restoring
// divider sharing one 2*WIDTH working register, with a sign-fix cycle and a one-cycle hi/lo write.
module hilo_md_ctrl #(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIVZ_LO = {WIDTH{1'b1}}
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_src1,
    input  logic [WIDTH-1:0] i_src2,
    input  logic             i_cancel,
    output logic             o_stallreq_for_md,
    output logic             o_busy,
    output logic             o_result_valid,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_work;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_is_div;
    logic               w_signed;
    logic               w_divz;
    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH+1:0]   w_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_fix;

    // op is nominally one-hot; overlapping bits resolve mult > multu > div > divu
    always_comb begin
        w_is_div = 1'b0;
        w_signed = 1'b0;
        priority casez (i_op)
            4'b1???: w_signed = 1'b1;
            4'b01??: w_signed = 1'b0;
            4'b001?: begin
                w_is_div = 1'b1;
                w_signed = 1'b1;
            end
            4'b0001: w_is_div = 1'b1;
            default: ;
        endcase
    end

    assign w_accept = (r_state == StIdle) & i_start & (|i_op) & ~i_cancel;
    assign w_divz   = w_is_div & (i_src2 == '0);
    assign w_abs1   = (w_signed & i_src1[WIDTH-1]) ? -i_src1 : i_src1;
    assign w_abs2   = (w_signed & i_src2[WIDTH-1]) ? -i_src2 : i_src2;

    // Multiply: conditional add into the upper half, keep the carry, shift right
    assign w_mul_sum  = {1'b0, r_work[2*WIDTH-1:WIDTH]} + (r_work[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_work[WIDTH-1:1]};

    // Divide: the shifted partial remainder needs WIDTH+1 bits before the trial subtract
    assign w_rem_sh   = r_work[2*WIDTH-1:WIDTH-1];
    assign w_diff     = {1'b0, w_rem_sh} - {2'b0, r_opnd};
    assign w_div_next = w_diff[WIDTH+1] ? {w_rem_sh[WIDTH-1:0], r_work[WIDTH-2:0], 1'b0}
                                        : {w_diff[WIDTH-1:0], r_work[WIDTH-2:0], 1'b1};

    always_comb begin
        w_fix = r_work;
        if (r_is_div) begin
            w_fix[2*WIDTH-1:WIDTH] = r_neg_rem ? -r_work[2*WIDTH-1:WIDTH]
                                               : r_work[2*WIDTH-1:WIDTH];
            w_fix[WIDTH-1:0]       = r_neg_res ? -r_work[WIDTH-1:0] : r_work[WIDTH-1:0];
        end else if (r_neg_res) begin
            w_fix = -r_work;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        o_stallreq_for_md = 1'b0;
        o_busy            = 1'b1;
        o_result_valid    = 1'b0;
        case (r_state)
            StIdle: begin
                o_busy            = 1'b0;
                o_stallreq_for_md = w_accept;
                if (w_accept) begin
                    w_state_nxt = w_divz ? StDone : StCalc;
                end
            end
            StCalc: begin
                o_stallreq_for_md = 1'b1;
                if (i_cancel) begin
                    w_state_nxt = StIdle;
                end else if (r_count == LAST) begin
                    w_state_nxt = StFix;
                end
            end
            StFix: begin
                o_stallreq_for_md = 1'b1;
                w_state_nxt       = i_cancel ? StIdle : StDone;
            end
            StDone: begin
                o_result_valid = 1'b1;
                w_state_nxt    = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count   <= '0;
            r_work    <= '0;
            r_opnd    <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_count   <= '0;
                        r_is_div  <= w_is_div;
                        r_neg_res <= w_signed & (i_src1[WIDTH-1] ^ i_src2[WIDTH-1]);
                        r_neg_rem <= w_signed & i_src1[WIDTH-1];
                        r_opnd    <= w_is_div ? w_abs2 : w_abs1;
                        r_work    <= {{WIDTH{1'b0}}, (w_is_div ? w_abs1 : w_abs2)};
                        if (w_divz) begin
                            r_hi <= i_src1;
                            r_lo <= DIVZ_LO;
                        end
                    end
                end
                StCalc: begin
                    if (!i_cancel) begin
                        r_work  <= r_is_div ? w_div_next : w_mul_next;
                        r_count <= r_count + 1'b1;
                    end
                end
                StFix: begin
                    if (!i_cancel) begin
                        r_hi <= w_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule
